// File: rtl/spi_slave_param.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_param
//  Brief    : Clock-synchronous SPI slave front end for a small RAM. Receives
//             an R/W bit plus a {opcode[1:0], payload} frame MSB first,
//             validates the opcode against the command phase, and serialises
//             one DATA_W-bit read word back on MISO.
//  Options  : define SPI_SLV_ERR_EN to add the one-cycle err strobe
//             (illegal opcode or SS_n abort).
//  Revision : 1.0 - initial release
// ============================================================================
module spi_slave_param #(
  parameter  int DATA_W  = 8,
  localparam int FRAME_W = DATA_W + 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SS_n,
  input  logic               MOSI,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid
`ifdef SPI_SLV_ERR_EN
  ,
  output logic               err
`endif
);

  localparam int                 c_CNT_W      = $clog2(FRAME_W + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ZERO   = '0;
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_FRAME_LAST = c_CNT_W'(FRAME_W - 1);
  localparam logic [c_CNT_W-1:0] c_SEND_LAST  = c_CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHK_CMD   = 3'd1,
    S_WRITE     = 3'd2,
    S_READ_ADD  = 3'd3,
    S_READ_DATA = 3'd4,
    S_WAIT_TX   = 3'd5,
    S_SEND      = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  // Holds the first FRAME_W-1 bits; the final bit joins combinationally.
  logic [FRAME_W-2:0]   r_sh, w_sh_nxt;
  logic [DATA_W-1:0]    r_tx, w_tx_nxt;
  logic                 r_rd_pending, w_rd_pending_nxt;
  logic [FRAME_W-1:0]   w_rx_data_nxt;
  logic                 w_rx_valid_nxt;
  logic [FRAME_W-1:0]   w_frame;
  logic [1:0]           w_op;
  logic                 w_op_ok;
`ifdef SPI_SLV_ERR_EN
  logic                 w_err_nxt;
`endif

  // Assemble the complete frame from the stored bits and the bit on MOSI now.
  assign w_frame = {r_sh, MOSI};
  assign w_op    = w_frame[FRAME_W-1 -: 2];

  // MISO carries data only while sending; it is quiet everywhere else.
  assign MISO = (r_state == S_SEND) ? r_tx[DATA_W-1] : 1'b0;

  // Next-state and datapath decisions; an SS_n release outranks everything.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_sh_nxt         = r_sh;
    w_tx_nxt         = r_tx;
    w_rd_pending_nxt = r_rd_pending;
    w_rx_data_nxt    = rx_data;
    w_rx_valid_nxt   = 1'b0;
    w_op_ok          = 1'b0;
`ifdef SPI_SLV_ERR_EN
    w_err_nxt        = 1'b0;
`endif
    if (r_state != S_IDLE && SS_n) begin
      // Abort: drop any partial frame; rd_pending survives for a retry.
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = c_CNT_ZERO;
      w_sh_nxt    = '0;
`ifdef SPI_SLV_ERR_EN
      if (r_state inside {S_WRITE, S_READ_ADD, S_READ_DATA, S_WAIT_TX, S_SEND})
        w_err_nxt = 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!SS_n) w_state_nxt = S_CHK_CMD;
        end
        S_CHK_CMD: begin
          w_cnt_nxt = c_CNT_ZERO;
          if (!MOSI)             w_state_nxt = S_WRITE;
          else if (r_rd_pending) w_state_nxt = S_READ_DATA;
          else                   w_state_nxt = S_READ_ADD;
        end
        S_WRITE, S_READ_ADD, S_READ_DATA: begin
          w_sh_nxt = w_frame[FRAME_W-2:0];
          if (r_cnt == c_FRAME_LAST) begin
            w_cnt_nxt = c_CNT_ZERO;
            case (r_state)
              S_WRITE:    w_op_ok = ~w_op[1];
              S_READ_ADD: w_op_ok = (w_op == 2'b10);
              default:    w_op_ok = (w_op == 2'b11);
            endcase
            if (w_op_ok) begin
              w_rx_data_nxt  = w_frame;
              w_rx_valid_nxt = 1'b1;
              if (r_state == S_READ_ADD) w_rd_pending_nxt = 1'b1;
              w_state_nxt = (r_state == S_READ_DATA) ? S_WAIT_TX : S_DONE;
            end else begin
              w_state_nxt = S_DONE;
`ifdef SPI_SLV_ERR_EN
              w_err_nxt   = 1'b1;
`endif
            end
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
          end
        end
        S_WAIT_TX: begin
          if (tx_valid) begin
            w_tx_nxt    = tx_data;
            w_cnt_nxt   = c_CNT_ZERO;
            w_state_nxt = S_SEND;
          end
        end
        S_SEND: begin
          w_tx_nxt = r_tx << 1;
          if (r_cnt == c_SEND_LAST) begin
            w_cnt_nxt        = c_CNT_ZERO;
            w_rd_pending_nxt = 1'b0;
            w_state_nxt      = S_DONE;
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
          end
        end
        S_DONE: begin
          // Bits clocked here are ignored; only SS_n release leaves DONE.
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= c_CNT_ZERO;
      r_sh         <= '0;
      r_tx         <= '0;
      r_rd_pending <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
`ifdef SPI_SLV_ERR_EN
      err          <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sh         <= w_sh_nxt;
      r_tx         <= w_tx_nxt;
      r_rd_pending <= w_rd_pending_nxt;
      rx_data      <= w_rx_data_nxt;
      rx_valid     <= w_rx_valid_nxt;
`ifdef SPI_SLV_ERR_EN
      err          <= w_err_nxt;
`endif
    end
  end

endmodule
`default_nettype wire
